// File: rtl/fadd_share_ctrl.sv
// rtl/fadd_share_ctrl.sv - round-robin sharing of one fixed-latency float_add among N requesters
module fadd_share_ctrl #(
  parameter int N   = 4,
  parameter int LAT = 6,
  parameter int IDW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  input  logic [N*32-1:0]   req_a,
  input  logic [N*32-1:0]   req_b,
  output logic [N-1:0]      req_ready,
  output logic [31:0]       fa_v1,
  output logic [31:0]       fa_v2,
  input  logic [31:0]       fa_vres,
  output logic [N-1:0]      rsp_valid,
  output logic [31:0]       rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic [IDW+3:0]    inflight
);

  logic [IDW-1:0] rr_ptr;
  logic           gnt_found;
  logic [IDW-1:0] gnt_id;
  logic           xfer;
  logic [LAT:0]   tag_v;
  logic [IDW-1:0] tag_id [0:LAT];

  // First pending requester at or after the pointer, wrapping modulo N.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_found && req_valid[(int'(rr_ptr) + k) % N]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'((int'(rr_ptr) + k) % N);
      end
    end
  end

  // Grant is masked during reset so nothing can be issued while state is cleared.
  assign xfer      = gnt_found & rst_n;
  assign req_ready = xfer ? (N'(1) << gnt_id) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      fa_v1     <= '0;
      fa_v2     <= '0;
      tag_v     <= '0;
      for (int k = 0; k <= LAT; k++) tag_id[k] <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      inflight  <= '0;
    end else begin
      tag_v     <= {tag_v[LAT-1:0], xfer};
      tag_id[0] <= xfer ? gnt_id : tag_id[0];
      for (int k = 1; k <= LAT; k++) tag_id[k] <= tag_id[k-1];
      if (xfer) begin
        fa_v1  <= req_a[32*gnt_id +: 32];
        fa_v2  <= req_b[32*gnt_id +: 32];
        rr_ptr <= (gnt_id == IDW'(N-1)) ? '0 : gnt_id + IDW'(1);
      end
      // The exiting tag lines up with the adder result now held in fa_vres.
      if (tag_v[LAT]) begin
        rsp_valid <= N'(1) << tag_id[LAT];
        rsp_data  <= fa_vres;
        rsp_id    <= tag_id[LAT];
      end else begin
        rsp_valid <= '0;
      end
      case ({xfer, tag_v[LAT]})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_fadd_share_ctrl.sv
// tb/tb_fadd_share_ctrl.sv - randomized and directed bench for fadd_share_ctrl with a behavioural model
module tb_fadd_share_ctrl;
  localparam int N   = 4;
  localparam int LAT = 6;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic [N-1:0]    req_ready;
  logic [31:0]     fa_v1, fa_v2, fa_vres;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_data;
  logic [IDW-1:0]  rsp_id;
  logic [IDW+3:0]  inflight;

  fadd_share_ctrl #(.N(N), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .fa_v1(fa_v1), .fa_v2(fa_v2), .fa_vres(fa_vres),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .inflight(inflight)
  );

  always #5 clk = ~clk;

  // Single-precision add through double arithmetic (normals only, truncating).
  function automatic real sp2real(input logic [31:0] a);
    logic [10:0] e;
    if (a[30:23] == 8'd0) return 0.0;
    e = 11'({3'b000, a[30:23]}) + 11'd896;
    return $bitstoreal({a[31], e, a[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(sp2real(a) + sp2real(b));
    e = d[62:52];
    if (e < 11'd897) return {d[63], 31'b0};
    if (e > 11'd1150) return {d[63], 8'hFF, 23'h0};
    return {d[63], 8'(e - 11'd896), d[51:29]};
  endfunction

  // Free-running adder stand-in: LAT register stages from v1/v2 to vres.
  logic [31:0] add_st [0:LAT-1];
  always @(posedge clk) begin
    add_st[0] <= fadd_model(fa_v1, fa_v2);
    for (int k = 1; k < LAT; k++) add_st[k] <= add_st[k-1];
  end
  assign fa_vres = add_st[LAT-1];

  typedef struct { int due; int id; logic [31:0] data; } ent_t;
  ent_t        exp_q[$];
  int          cyc = 0;
  int          mp = 0;
  logic [31:0] e_v1 = '0, e_v2 = '0, e_rdata = '0;
  int          e_rid = 0;
  logic [N-1:0] e_rv = '0;
  int          checks = 0, failures = 0;
  int          last_grant;
  logic [N-1:0] seen_ready;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  // One clock: drive inputs, check the grant, advance the model, check registered outputs.
  task automatic step(input logic [N-1:0] v, input bit fixed, input logic [31:0] fa, input logic [31:0] fb);
    logic [N-1:0] exp_ready;
    int eg;
    req_valid = v;
    for (int k = 0; k < N; k++) begin
      req_a[k*32 +: 32] = fixed ? fa : rnd_fp();
      req_b[k*32 +: 32] = fixed ? fb : rnd_fp();
    end
    #1;
    eg = -1;
    if (!rst_n) begin
      exp_q.delete();
      mp = 0; e_v1 = '0; e_v2 = '0; e_rdata = '0; e_rid = 0;
    end else begin
      for (int k = 0; k < N; k++)
        if (eg < 0 && v[(mp + k) % N]) eg = (mp + k) % N;
    end
    exp_ready = (eg >= 0) ? N'(1 << eg) : '0;
    seen_ready = req_ready;
    last_grant = eg;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    @(posedge clk);
    cyc++;
    e_rv = '0;
    if (rst_n) begin
      if (eg >= 0) begin
        exp_q.push_back('{due: cyc + LAT + 1, id: eg,
                          data: fadd_model(req_a[eg*32 +: 32], req_b[eg*32 +: 32])});
        e_v1 = req_a[eg*32 +: 32];
        e_v2 = req_b[eg*32 +: 32];
        mp = (eg + 1) % N;
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e_rv = N'(1 << exp_q[0].id);
        e_rid = exp_q[0].id;
        e_rdata = exp_q[0].data;
        void'(exp_q.pop_front());
      end
    end
    #1;
    chk("fa_v1", 64'(fa_v1), 64'(e_v1));
    chk("fa_v2", 64'(fa_v2), 64'(e_v2));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    chk("rsp_data", 64'(rsp_data), 64'(e_rdata));
    chk("rsp_id", 64'(rsp_id), 64'(e_rid));
    chk("inflight", 64'(inflight), 64'(exp_q.size()));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b0, '0, '0);
  endtask

  initial begin
    int lat, rdat, rid, peak, nrsp;
    logic [N-1:0] rv;
    int hist [0:14];
    int pat [0:4];
    pat = '{1, 0, 1, 1, 0};

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) step(N'($urandom), 1'b0, '0, '0);
    rst_n = 1'b1;
    idle(20);

    // Single issue from requester 2: 3.0 + 1.0.
    step(4'b0100, 1'b1, 32'h40400000, 32'h3F800000);
    chk("single_grant", 64'(seen_ready), 64'h4);
    chk("single_inflight", 64'(inflight), 64'd1);
    lat = -1; rdat = 0; rid = -1; rv = '0;
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      if (rsp_valid != 0 && lat < 0) begin
        lat = k; rdat = rsp_data; rid = rsp_id; rv = rsp_valid;
      end
    end
    chk("single_latency", 64'(lat), 64'd7);
    chk("single_data", 64'(rdat), 64'h40800000);
    chk("single_id", 64'(rid), 64'd2);
    chk("single_rsp_valid", 64'(rv), 64'h4);
    chk("single_inflight_end", 64'(inflight), 64'd0);

    // Bring the pointer to 0, then full load for 8 cycles.
    step(4'b1000, 1'b0, '0, '0);
    idle(10);
    peak = 0;
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 1'b0, '0, '0);
      chk("rr_order", 64'(last_grant), 64'(k % 4));
      if (int'(inflight) > peak) peak = int'(inflight);
    end
    for (int k = 0; k < 10; k++) begin
      idle(1);
      if (int'(inflight) > peak) peak = int'(inflight);
    end
    chk("rr_peak_inflight", 64'(peak), 64'd7);

    // Wrap and skip from pointer 3.
    step(4'b0100, 1'b0, '0, '0);
    chk("wrap_setup", 64'(last_grant), 64'd2);
    step(4'b0011, 1'b0, '0, '0);
    chk("wrap_first", 64'(seen_ready), 64'h1);
    step(4'b0011, 1'b0, '0, '0);
    chk("wrap_second", 64'(seen_ready), 64'h2);
    step(4'b1000, 1'b0, '0, '0);
    chk("skip_to_3", 64'(seen_ready), 64'h8);
    idle(10);

    // Gapped issue pattern from requester 1.
    for (int s = 0; s < 15; s++) begin
      step((s < 5 && pat[s] == 1) ? 4'b0010 : 4'b0000, 1'b0, '0, '0);
      hist[s] = int'(rsp_valid[1]);
    end
    for (int i = 0; i < 5; i++) chk("gap_pattern", 64'(hist[i+7]), 64'(pat[i]));

    // Reset while three operations are in flight.
    for (int k = 0; k < 3; k++) step(4'b0001, 1'b0, '0, '0);
    idle(2);
    rst_n = 1'b0;
    step(4'b0000, 1'b0, '0, '0);
    rst_n = 1'b1;
    chk("reset_inflight", 64'(inflight), 64'd0);
    nrsp = 0;
    for (int k = 0; k < 15; k++) begin
      idle(1);
      if (rsp_valid != 0) nrsp++;
    end
    chk("reset_no_rsp", 64'(nrsp), 64'd0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      rst_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      step(($urandom_range(0, 3) == 0) ? 4'b0000 : N'($urandom), 1'b0, '0, '0);
    end
    rst_n = 1'b1;
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
